dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters:
  - the pipeline MEM stage (core);
  - an external loader/debug port (ext), used for program/data preload and result dump.
- Sits between the Datapath MEM stage and the data memory.
- Issues at most one memory access per cycle and routes synchronous-read data back to the owner.
- Stalls the core whenever it loses the port.

---
 rtl/dmem_port_arbiter.sv | 94 +++++++++
 tb/tb_dmem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: pipeline MEM stage (core)
// versus loader/debug port (ext), with bounded core bursts and an ext lock mode.
module dmem_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              e_req,
    input  logic              e_we,
    input  logic              e_lock,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic {SHARED, LOCKED} state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t     state_q, state_d;
    logic [3:0] burst_q, burst_d;
    logic [3:0] burst_eff;
    logic       c_rv_q, e_rv_q;

    always_comb begin
        c_gnt     = 1'b0;
        e_gnt     = 1'b0;
        state_d   = state_q;
        burst_d   = burst_q;
        burst_eff = burst_q;
        if (reset) begin
            state_d = SHARED;
            burst_d = '0;
        end else if (state_q == LOCKED && e_lock) begin
            e_gnt   = e_req;
            burst_d = '0;
        end else begin
            // The cycle that drops the lock is arbitrated as SHARED with a fresh burst count.
            burst_eff = (state_q == LOCKED) ? 4'd0 : burst_q;
            if (c_req && e_req) begin
                if (burst_eff == BURST_MAX) e_gnt = 1'b1;
                else                        c_gnt = 1'b1;
            end else begin
                c_gnt = c_req;
                e_gnt = e_req;
            end
            if (e_gnt || !e_req)            burst_d = '0;
            else if (burst_eff != BURST_MAX) burst_d = burst_eff + 4'd1;
            else                            burst_d = burst_eff;
            state_d = (e_gnt && e_lock) ? LOCKED : SHARED;
        end
    end

    assign c_stall   = c_req & ~c_gnt & ~reset;
    assign mem_wr    = (c_gnt & c_we) | (e_gnt & e_we);
    assign mem_rd    = (c_gnt & ~c_we) | (e_gnt & ~e_we);
    assign mem_addr  = c_gnt ? c_addr  : (e_gnt ? e_addr  : '0);
    assign mem_wdata = c_gnt ? c_wdata : (e_gnt ? e_wdata : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SHARED;
            burst_q <= '0;
            c_rv_q  <= 1'b0;
            e_rv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            c_rv_q  <= c_gnt & ~c_we;
            e_rv_q  <= e_gnt & ~e_we;
        end
    end

    assign c_rvalid = c_rv_q;
    assign e_rvalid = e_rv_q;
    assign c_rdata  = c_rv_q ? mem_rdata : '0;
    assign e_rdata  = e_rv_q ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized + directed bench for dmem_port_arbiter: a behavioural arbitration model
// predicts grants and memory drive; a scoreboard queue checks read returns.
module tb_dmem_port_arbiter;
    localparam int DW = 32, AW = 9, MB = 4;

    logic          clk = 1'b0, reset = 1'b1;
    logic          c_req = 0, c_we = 0, e_req = 0, e_we = 0, e_lock = 0;
    logic [AW-1:0] c_addr = '0, e_addr = '0;
    logic [DW-1:0] c_wdata = '0, e_wdata = '0;
    logic          c_gnt, c_stall, c_rvalid, e_gnt, e_rvalid, mem_wr, mem_rd;
    logic [DW-1:0] c_rdata, e_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .e_req(e_req), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: synchronous read, one-cycle latency.
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= env_mem[mem_addr];
        if (mem_wr) env_mem[mem_addr] = mem_wdata;
    end

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit own_e; logic [DW-1:0] data; int due; } rd_t;
    rd_t           sb[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    // Reference arbitration state: whether ext owns the port, and how many core
    // grants ext has already sat through while asking.
    bit m_locked = 0;
    int m_waited = 0;

    logic cg_s, eg_s, cst_s, crv_s, erv_s;
    logic [DW-1:0] crd_s;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit xc, xe, xst;
        int waited;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        @(negedge clk);
        xc = 0; xe = 0; waited = m_waited;
        if (reset) begin
            m_locked = 0; m_waited = 0;
        end else begin
            if (m_locked && e_lock) xe = e_req;
            else begin
                if (m_locked) waited = 0;
                if (c_req && e_req) begin
                    if (waited >= MB) xe = 1; else xc = 1;
                end else begin
                    xc = c_req; xe = e_req;
                end
            end
        end
        xst = !reset && c_req && !xc;
        xa  = xc ? c_addr  : xe ? e_addr  : '0;
        xd  = xc ? c_wdata : xe ? e_wdata : '0;
        chk("c_gnt",     64'(c_gnt),     64'(xc));
        chk("e_gnt",     64'(e_gnt),     64'(xe));
        chk("c_stall",   64'(c_stall),   64'(xst));
        chk("mem_wr",    64'(mem_wr),    64'((xc && c_we) || (xe && e_we)));
        chk("mem_rd",    64'(mem_rd),    64'((xc && !c_we) || (xe && !e_we)));
        chk("mem_addr",  64'(mem_addr),  64'(xa));
        chk("mem_wdata", 64'(mem_wdata), 64'(xd));
        if ((xc && !c_we) || (xe && !e_we))
            sb.push_back('{own_e: xe, data: ref_mem[xa], due: cyc + 1});
        if ((xc && c_we) || (xe && e_we)) ref_mem[xa] = xd;
        if (!reset) begin
            if (m_locked && e_lock) begin
                m_waited = 0;
            end else begin
                m_locked = xe && e_lock;
                if (xe || !e_req) m_waited = 0;
                else m_waited = (waited + 1 > MB) ? MB : waited + 1;
            end
        end
        cg_s = c_gnt; eg_s = e_gnt; cst_s = c_stall;
        crv_s = c_rvalid; erv_s = e_rvalid; crd_s = c_rdata;
        @(posedge clk); #1;
    endtask

    // Monitor: every rvalid must match the oldest outstanding read, on time.
    always @(negedge clk) begin
        if (c_rvalid && e_rvalid) begin
            total++; bad++;
            $display("FAIL both_rvalid: got 1 want 0 (cycle %0d)", cyc);
        end
        if (c_rvalid || e_rvalid) begin
            total++;
            if (sb.size() == 0 || sb[0].due != cyc) begin
                bad++;
                $display("FAIL unexpected_rvalid: got c=%0b e=%0b want none (cycle %0d)",
                         c_rvalid, e_rvalid, cyc);
            end else begin
                if (sb[0].own_e != e_rvalid) begin
                    bad++;
                    $display("FAIL rd_owner: got e=%0b want e=%0b (cycle %0d)", e_rvalid, sb[0].own_e, cyc);
                end else if ((e_rvalid ? e_rdata : c_rdata) !== sb[0].data) begin
                    bad++;
                    $display("FAIL rd_data: got %0h want %0h (cycle %0d)",
                             e_rvalid ? e_rdata : c_rdata, sb[0].data, cyc);
                end
                void'(sb.pop_front());
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            total++; bad++;
            $display("FAIL missing_rvalid: got 0 want 1 (cycle %0d)", cyc);
            void'(sb.pop_front());
        end
        total++;
        if ((!c_rvalid && c_rdata !== '0) || (!e_rvalid && e_rdata !== '0)) begin
            bad++;
            $display("FAIL idle_rdata: got c=%0h e=%0h want 0 (cycle %0d)", c_rdata, e_rdata, cyc);
        end
    end

    initial begin
        int n_c, n_e, n_st;
        logic [9:0] pat;
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = $urandom;
            env_mem[i] = ref_mem[i];
        end
        ref_mem[4] = 32'hDEADBEEF; env_mem[4] = 32'hDEADBEEF;

        // Reset state with requests pending: everything must stay quiet.
        c_req = 1; e_req = 1;
        step(); step();
        c_req = 0; e_req = 0;
        reset = 0;
        step();

        // Read in flight dropped by reset.
        c_req = 1; c_we = 0; c_addr = 9'h010;
        step();
        chk("rst_rd_gnt", 64'(cg_s), 64'd1);
        reset = 1; c_req = 0; sb.delete();
        step();
        chk("rst_rvalid", 64'(crv_s), 64'd0);
        reset = 0;
        step();

        // Core-only read.
        c_req = 1; c_we = 0; c_addr = 9'h004;
        step();
        chk("core_rd_stall", 64'(cst_s), 64'd0);
        c_req = 0;
        step();
        chk("core_rd_rvalid", 64'(crv_s), 64'd1);
        chk("core_rd_data",   64'(crd_s), 64'h0DEADBEEF);

        // Ext write then core read of the same word.
        e_req = 1; e_we = 1; e_addr = 9'h1FF; e_wdata = 32'h12345678;
        step();
        e_req = 0;
        c_req = 1; c_we = 0; c_addr = 9'h1FF;
        step();
        c_req = 0;
        step();
        chk("wr_rd_data", 64'(crd_s), 64'h012345678);

        // Fairness: 4 core grants then one ext grant, repeating.
        c_req = 1; c_we = 1; c_addr = 9'h030; c_wdata = 32'hC0C0C0C0;
        e_req = 1; e_we = 1; e_addr = 9'h031; e_wdata = 32'hE0E0E0E0;
        n_c = 0; n_e = 0; n_st = 0; pat = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_c += int'(cg_s); n_e += int'(eg_s); n_st += int'(cst_s && eg_s);
            pat[i] = eg_s;
        end
        chk("fair_pattern", 64'(pat), 64'h210);
        chk("fair_core_n",  64'(n_c), 64'd8);
        chk("fair_stall_n", 64'(n_st), 64'd2);

        // Lock: ext takes the port, core stalls for 6 cycles, then a fresh burst.
        c_req = 0; e_lock = 1;
        step();
        c_req = 1;
        n_c = 0; n_st = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_c += int'(cg_s); n_st += int'(cst_s);
        end
        chk("lock_core_gnt", 64'(n_c), 64'd0);
        chk("lock_stall_n",  64'(n_st), 64'd6);
        e_lock = 0; pat = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            pat[i] = eg_s;
            if (i == 0) chk("unlock_core_gnt", 64'(cg_s), 64'd1);
        end
        chk("unlock_pattern", 64'(pat), 64'h10);
        c_req = 0; e_req = 0;
        step();

        // Alternating reads return to their own owners.
        c_req = 1; c_we = 0; c_addr = 9'h020;
        step();
        c_req = 0;
        e_req = 1; e_we = 0; e_addr = 9'h021;
        step();
        chk("alt_c_rvalid", 64'({crv_s, erv_s}), 64'b10);
        e_req = 0;
        step();
        chk("alt_e_rvalid", 64'({crv_s, erv_s}), 64'b01);
        step();

        // Randomized traffic; requesters hold their fields until granted.
        for (int i = 0; i < 3000; i++) begin
            if (!c_req || cg_s) begin
                c_req = ($urandom_range(0, 3) != 0); c_we = 1'($urandom_range(0, 1));
                c_addr = 9'($urandom_range(0, 31)); c_wdata = $urandom;
            end
            if (!e_req || eg_s) begin
                e_req = ($urandom_range(0, 2) != 0); e_we = 1'($urandom_range(0, 1));
                e_addr = 9'($urandom_range(0, 31)); e_wdata = $urandom;
            end
            if ($urandom_range(0, 9) == 0) e_lock = ~e_lock;
            step();
        end
        c_req = 0; e_req = 0; e_lock = 0;
        step(); step(); step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
